misaligned_access_ctrl: RTL
===========================

Name: misaligned_access_ctrl

Overview:
Sequencer between the CPU data-memory port and the D-cache port. Splits any access whose shifted byte enables cross a 4-byte word boundary into two aligned cache accesses (low word, then high word). Shifts write data and byte enables per word, merges the two read words back into one CPU-aligned word, and returns a single CPU response. Non-crossing accesses pass through as one aligned cache access.

Parameters:
ADDR_W, 32, address width; the low 2 bits are the byte offset.
DATA_W, 32, data width; fixed at 4 byte lanes.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_read  in  1  read request
cpu_write  in  1  write request
cpu_address  in  32  byte address, any alignment
cpu_wdata  in  32  write data, LSB-justified
cpu_byte_enable  in  4  LSB-justified enables: 0001 byte, 0011 half, 1111 word
cpu_rdata  out  32  LSB-justified read data
cpu_resp  out  1  one-cycle completion pulse
cache_read  out  1  aligned cache read
cache_write  out  1  aligned cache write
cache_address  out  32  word-aligned address, [1:0]=00
cache_wdata  out  32  lane-positioned write data
cache_byte_enable  out  4  lane enables
cache_rdata  in  32  cache read data, valid with cache_resp
cache_resp  in  1  cache completion pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cpu_resp, cache_read, cache_write=0; cpu_rdata, cache_address, cache_wdata, cache_byte_enable=0. A reset mid-operation abandons the access and drops cache_read/write immediately.
- States: IDLE, ACC_LO, ACC_HI, DONE.
- IDLE:
  - Accepts a request when cpu_read|cpu_write. Read wins if both are asserted.
  - Latches addr, wdata, be, op. off=addr[1:0]; ext_be[7:0]={4'b0,be}<<off; ext_wd[63:0]={32'b0,wdata}<<(off*8).
  - Goes to ACC_LO next cycle.
- ACC_LO:
  - Drives cache_address={addr[31:2],2'b00}, cache_byte_enable=ext_be[3:0], cache_wdata=ext_wd[31:0], plus read or write.
  - Holds all outputs stable until cache_resp.
  - On cache_resp: latches lo_rdata=cache_rdata. If ext_be[7:4]!=0, goes to ACC_HI; otherwise goes to DONE.
- ACC_HI:
  - Drives cache_address={addr[31:2]+1,2'b00}, cache_byte_enable=ext_be[7:4], cache_wdata=ext_wd[63:32].
  - The word address wraps modulo 2^30 (0xFFFFFFFF spill goes to 0x00000000); no fault is raised.
  - On cache_resp: goes to DONE.
- Read merge: cpu_rdata=({hi_rdata,lo_rdata}>>(off*8))[31:0]; hi_rdata=0 when the access is single. cpu_rdata is registered and holds until the next accepted read.
- DONE: cpu_resp=1 for exactly one cycle, cache_read/write=0, then returns to IDLE.
- The CPU deasserts its request on the edge after cpu_resp, so IDLE never re-accepts the same request.
- Latency: a single access has 1 cycle of accept overhead plus the cache latency, plus 1 DONE cycle. A split access adds a second cache latency and no extra bubble between ACC_LO and ACC_HI.
- CPU inputs are ignored outside IDLE. cache_resp outside ACC_LO/ACC_HI is ignored.
- be=0000 is treated as a single access with no enabled lanes; it still produces one cache access and cpu_resp.

Optional Feature:
MISALIGN_STATS_EN
- Defined: adds output split_count[31:0]. It resets to 0, increments by 1 on each entry to ACC_HI, and saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package misalign_pkg:
  - state_t enum {IDLE, ACC_LO, ACC_HI, DONE}
  - constants BYTES_PER_WORD=4, OFF_W=2
  - function crosses_word(be, off)
- Sub-module misalign_lane_shift (combinational):
  - produces ext_be, ext_wd and the read merge from off;
  - instantiated once so lane maths is verified in isolation.

Test Plan:
- Aligned word read: addr 0x100, be 1111, cache returns 0xDEADBEEF after 2 cycles -> one access at 0x100; cpu_rdata=0xDEADBEEF; one cpu_resp.
- Half read at offset 3: addr 0x103, be 0011; lo word 0x11223344, hi word 0x55667788 -> accesses at 0x100 be 1000, then 0x104 be 0001; cpu_rdata=0x00008811.
- Word write at offset 2: addr 0x202, wdata 0xAABBCCDD, be 1111 -> access 0x200 be 1100 wdata[31:16]=0xCCDD, then 0x204 be 0011 wdata[15:0]=0xAABB; one cpu_resp.
- Wrap: word write at 0xFFFFFFFE -> second access at 0x00000000 be 0011; no hang.
- Reset mid-op: rst_n low while in ACC_HI -> cache_write=0 at once; after release, state IDLE; the next aligned read completes normally.
- Stats (MISALIGN_STATS_EN): three split accesses and two aligned accesses -> split_count=3.

Source files
------------

// File: rtl/misalign_pkg.sv
// Shared types and lane helpers for the misaligned access sequencer.
// Provides the sequencer state enum, lane geometry and the word-crossing test.
package misalign_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int OFF_W          = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        DONE
    } state_t;

    // True when the enables, moved to their lanes, spill into the next word.
    function automatic logic crosses_word(
        input logic [BYTES_PER_WORD-1:0] be,
        input logic [OFF_W-1:0]          off
    );
        logic [2*BYTES_PER_WORD-1:0] e;
        e = {{BYTES_PER_WORD{1'b0}}, be} << off;
        return |e[2*BYTES_PER_WORD-1:BYTES_PER_WORD];
    endfunction

endpackage

// File: rtl/misalign_lane_shift.sv
// Combinational lane maths: moves enables/write data up by the byte offset
// across a two-word window and merges two read words back to CPU alignment.
// Ports: off, be, wdata, lo_rdata, hi_rdata in; ext_be, ext_wd, rdata out.
module misalign_lane_shift
    import misalign_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [OFF_W-1:0]            off,
    input  logic [BYTES_PER_WORD-1:0]   be,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W-1:0]           lo_rdata,
    input  logic [DATA_W-1:0]           hi_rdata,
    output logic [2*BYTES_PER_WORD-1:0] ext_be,
    output logic [2*DATA_W-1:0]         ext_wd,
    output logic [DATA_W-1:0]           rdata
);

    logic [4:0]        bit_sh;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] lane_mask;

    always_comb begin
        bit_sh    = {off, 3'b000};
        ext_be    = {{BYTES_PER_WORD{1'b0}}, be} << off;
        ext_wd    = {{DATA_W{1'b0}}, wdata} << bit_sh;
        shifted   = DATA_W'({hi_rdata, lo_rdata} >> bit_sh);
        lane_mask = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            lane_mask[8*i +: 8] = {8{be[i]}};
        end
        // Lanes the CPU did not ask for read back as zero.
        rdata = shifted & lane_mask;
    end

endmodule

// File: rtl/misaligned_access_ctrl.sv
// Splits CPU data accesses that straddle a word into two aligned cache
// accesses and returns one merged response. Optional: MISALIGN_STATS_EN
// adds split_count. Ports: clk, rst_n, cpu_* request/response, cache_* port.
module misaligned_access_ctrl
    import misalign_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cpu_read,
    input  logic                      cpu_write,
    input  logic [ADDR_W-1:0]         cpu_address,
    input  logic [DATA_W-1:0]         cpu_wdata,
    input  logic [BYTES_PER_WORD-1:0] cpu_byte_enable,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_resp,
    output logic                      cache_read,
    output logic                      cache_write,
    output logic [ADDR_W-1:0]         cache_address,
    output logic [DATA_W-1:0]         cache_wdata,
    output logic [BYTES_PER_WORD-1:0] cache_byte_enable,
    input  logic [DATA_W-1:0]         cache_rdata,
    input  logic                      cache_resp
`ifdef MISALIGN_STATS_EN
    ,
    output logic [31:0]               split_count
`endif
);

    state_t                      state_q;
    logic [ADDR_W-1:0]           addr_q;
    logic [DATA_W-1:0]           wdata_q;
    logic [BYTES_PER_WORD-1:0]   be_q;
    logic                        rd_q;
    logic [DATA_W-1:0]           lo_q;

    logic [OFF_W-1:0]            off_s;
    logic [BYTES_PER_WORD-1:0]   be_s;
    logic [DATA_W-1:0]           wd_s;
    logic [DATA_W-1:0]           lo_in;
    logic [DATA_W-1:0]           hi_in;
    logic [2*BYTES_PER_WORD-1:0] ext_be;
    logic [2*DATA_W-1:0]         ext_wd;
    logic [DATA_W-1:0]           merged;
    logic [ADDR_W-3:0]           word_nxt;
    logic                        split;

    // In IDLE the shifter sees the live request so the first cache
    // access can be registered on the accept edge.
    always_comb begin
        if (state_q == IDLE) begin
            off_s = cpu_address[OFF_W-1:0];
            be_s  = cpu_byte_enable;
            wd_s  = cpu_wdata;
        end else begin
            off_s = addr_q[OFF_W-1:0];
            be_s  = be_q;
            wd_s  = wdata_q;
        end
        lo_in    = (state_q == ACC_LO) ? cache_rdata : lo_q;
        hi_in    = (state_q == ACC_HI) ? cache_rdata : '0;
        word_nxt = addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};
        split    = crosses_word(be_q, addr_q[OFF_W-1:0]);
    end

    misalign_lane_shift #(
        .DATA_W (DATA_W)
    ) u_lane_shift (
        .off      (off_s),
        .be       (be_s),
        .wdata    (wd_s),
        .lo_rdata (lo_in),
        .hi_rdata (hi_in),
        .ext_be   (ext_be),
        .ext_wd   (ext_wd),
        .rdata    (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            addr_q            <= '0;
            wdata_q           <= '0;
            be_q              <= '0;
            rd_q              <= 1'b0;
            lo_q              <= '0;
            cpu_rdata         <= '0;
            cpu_resp          <= 1'b0;
            cache_read        <= 1'b0;
            cache_write       <= 1'b0;
            cache_address     <= '0;
            cache_wdata       <= '0;
            cache_byte_enable <= '0;
`ifdef MISALIGN_STATS_EN
            split_count       <= '0;
`endif
        end else begin
            cpu_resp <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu_read || cpu_write) begin
                        addr_q            <= cpu_address;
                        wdata_q           <= cpu_wdata;
                        be_q              <= cpu_byte_enable;
                        rd_q              <= cpu_read;
                        cache_read        <= cpu_read;
                        cache_write       <= !cpu_read;
                        cache_address     <= {cpu_address[ADDR_W-1:2], 2'b00};
                        cache_byte_enable <= ext_be[BYTES_PER_WORD-1:0];
                        cache_wdata       <= ext_wd[DATA_W-1:0];
                        state_q           <= ACC_LO;
                    end
                end
                ACC_LO: begin
                    if (cache_resp) begin
                        lo_q <= cache_rdata;
                        if (split) begin
                            cache_address     <= {word_nxt, 2'b00};
                            cache_byte_enable <= ext_be[2*BYTES_PER_WORD-1:BYTES_PER_WORD];
                            cache_wdata       <= ext_wd[2*DATA_W-1:DATA_W];
                            state_q           <= ACC_HI;
`ifdef MISALIGN_STATS_EN
                            if (split_count != 32'hFFFF_FFFF) begin
                                split_count <= split_count + 32'd1;
                            end
`endif
                        end else begin
                            cache_read  <= 1'b0;
                            cache_write <= 1'b0;
                            cpu_resp    <= 1'b1;
                            if (rd_q) begin
                                cpu_rdata <= merged;
                            end
                            state_q <= DONE;
                        end
                    end
                end
                ACC_HI: begin
                    if (cache_resp) begin
                        cache_read  <= 1'b0;
                        cache_write <= 1'b0;
                        cpu_resp    <= 1'b1;
                        if (rd_q) begin
                            cpu_rdata <= merged;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
